mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
- clk, input, 1: rising-edge clock.
- reset, input, 1: when sampled high on a clk edge, the block returns to its reset state.

REQ-002 The remaining ports SHALL be:
- opcode, input, 6: IR[31:26].
- funct, input, 6: IR[5:0].
- zero, input, 1: ALU equality flag.
- dm_ack, input, 1: data-memory access complete.
- PC_WE, output, 1: PC write enable.
- NPCOp, output, 2: next-PC source. 00 = PC+4, 01 = branch, 10 = jump target, 11 = GRF rs.
- IR_WE, output, 1: instruction register write enable.
- GRF_WE, output, 1: register file write enable.
- DM_WE, output, 1: data memory write enable.
- dm_req, output, 1: data-memory access request.
- GRF_WDSel, output, 3: write-data mux select. 000 = ALU, 001 = DM, 010 = PC+4.
- GRF_A3Sel, output, 3: write-address mux select. 000 = rt, 001 = rd, 010 = $31.
- ALU_ASel, output, 1: ALU A operand select. 0 = GRF RD1, 1 = zero constant.
- ALU_BSel, output, 3: ALU B operand select. 000 = GRF RD2, 001 = extended immediate.
- ALUOp, output, 3: 000 = add, 001 = sub, 010 = or, 011 = lui-shift.
- EXTOp, output, 1: 0 = zero-extend, 1 = sign-extend.
- illegal, output, 1: one-cycle pulse on an unsupported instruction.
- instr_cnt, output, 32: count of retired instructions.

Function
REQ-003 The FSM SHALL have the states FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3 and WB = 4, held in a 3-bit state register.

REQ-004 Outputs SHALL be combinational decodes of state, opcode, funct and zero. Every output that is not stated for a state SHALL be 0.

REQ-005 FETCH SHALL assert IR_WE = 1 and PC_WE = 1 with NPCOp = 00, then go to DECODE.

REQ-006 DECODE SHALL classify the instruction from opcode and funct:
- Supported: addu (000000/100001), subu (000000/100011), jr (000000/001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), jal (000011).
- jal goes to WB.
- Any other encoding pulses illegal and goes to FETCH. It has no writes and is not retired.
- All other supported instructions go to EXEC.

REQ-007 EXEC SHALL drive the ALU and pick the next state as follows:
- addu: ALUOp = 000, ALU_BSel = 000; next WB.
- subu: ALUOp = 001, ALU_BSel = 000; next WB.
- ori: ALUOp = 010, ALU_BSel = 001, EXTOp = 0; next WB.
- lui: ALU_ASel = 1, ALUOp = 011, ALU_BSel = 001; next WB.
- lw and sw: ALUOp = 000, ALU_BSel = 001, EXTOp = 1; next MEM.
- beq: ALUOp = 001, ALU_BSel = 000, EXTOp = 1, PC_WE = zero, NPCOp = 01; next FETCH.
- jr: PC_WE = 1, NPCOp = 11; next FETCH.

REQ-008 MEM SHALL assert dm_req = 1, and also DM_WE = 1 for sw.
- While dm_ack = 0 the FSM stays in MEM and all outputs hold their values.
- When dm_ack = 1, lw goes to WB and sw goes to FETCH.

REQ-009 WB SHALL assert GRF_WE = 1 and then go to FETCH. The selects are:
- R-type: GRF_A3Sel = 001, GRF_WDSel = 000.
- ori and lui: GRF_A3Sel = 000, GRF_WDSel = 000.
- lw: GRF_A3Sel = 000, GRF_WDSel = 001.
- jal: GRF_A3Sel = 010, GRF_WDSel = 010, plus PC_WE = 1 and NPCOp = 10.

REQ-010 Latency SHALL be, from FETCH to the next FETCH:
- beq and jr: 3 cycles.
- jal: 3 cycles.
- R-type, ori and lui: 4 cycles.
- sw: 4 + k cycles, where k is the number of MEM cycles with dm_ack = 0.
- lw: 5 + k cycles.

REQ-011 instr_cnt SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, and SHALL wrap from 0xFFFFFFFF to 0.

REQ-012 An illegal instruction SHALL NOT increment instr_cnt.

REQ-013 opcode and funct SHALL be assumed stable from DECODE until the return to FETCH. IR_WE is asserted only in FETCH.

REQ-014 dm_ack SHALL be ignored in every state except MEM. A dm_ack pulse that arrives early is lost, not queued.

Reset
REQ-015 On a clk edge with reset = 1, state SHALL become FETCH and instr_cnt SHALL become 0.

REQ-016 While reset = 1, PC_WE, IR_WE, GRF_WE, DM_WE, dm_req and illegal SHALL be forced to 0.

REQ-017 Reset SHALL take priority over every transition, including a dm_ack arriving in MEM. A reset in the middle of an instruction abandons it without any write.

REQ-018 On the first edge after reset deasserts, the FSM SHALL be in FETCH and the FETCH outputs take effect.

Verification
REQ-019 addu (opcode 000000, funct 100001) with no stalls -> states FETCH, DECODE, EXEC, WB, FETCH. GRF_WE = 1 only in the WB cycle, with GRF_A3Sel = 001. instr_cnt goes 0 to 1.

REQ-020 lw with dm_ack low for 2 MEM cycles -> MEM lasts 3 cycles with dm_req = 1 throughout. Then WB with GRF_WDSel = 001. Total 7 cycles.

REQ-021 beq with zero = 1, then beq with zero = 0 -> in EXEC, PC_WE = 1 with NPCOp = 01 for the first and PC_WE = 0 for the second. Each takes 3 cycles.

REQ-022 jal -> WB in the third cycle with GRF_A3Sel = 010, GRF_WDSel = 010, PC_WE = 1 and NPCOp = 10. Separately, opcode 111111 -> illegal pulses for 1 cycle in DECODE, the FSM returns to FETCH, and instr_cnt is unchanged.

REQ-023 sw with reset asserted during MEM while dm_ack = 1 -> the next state is FETCH, DM_WE = 0 in the reset cycle, and instr_cnt = 0.

REQ-024 instr_cnt preloaded near 0xFFFFFFFF (via a bench force), then 2 ori instructions retired -> the count reads 0xFFFFFFFF, then 0x00000000.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// with combinational control decode and a retired-instruction counter.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        dm_ack,
    output logic        PC_WE,
    output logic [1:0]  NPCOp,
    output logic        IR_WE,
    output logic        GRF_WE,
    output logic        DM_WE,
    output logic        dm_req,
    output logic [2:0]  GRF_WDSel,
    output logic [2:0]  GRF_A3Sel,
    output logic        ALU_ASel,
    output logic [2:0]  ALU_BSel,
    output logic [2:0]  ALUOp,
    output logic        EXTOp,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
    logic is_legal;

    assign is_r     = (opcode == 6'b000000);
    assign is_addu  = is_r && (funct == 6'b100001);
    assign is_subu  = is_r && (funct == 6'b100011);
    assign is_jr    = is_r && (funct == 6'b001000);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_jal   = (opcode == 6'b000011);
    assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_jal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: state_d = !is_legal ? FETCH : (is_jal ? WB : EXEC);
            EXEC: begin
                if (is_lw || is_sw)       state_d = MEM;
                else if (is_beq || is_jr) state_d = FETCH;
                else                      state_d = WB;
            end
            MEM:    if (dm_ack) state_d = is_lw ? WB : FETCH;
            WB:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Retirement is any return to FETCH except the one out of DECODE (illegal).
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB))
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;

    always_comb begin
        PC_WE     = 1'b0;
        NPCOp     = 2'b00;
        IR_WE     = 1'b0;
        GRF_WE    = 1'b0;
        DM_WE     = 1'b0;
        dm_req    = 1'b0;
        GRF_WDSel = 3'b000;
        GRF_A3Sel = 3'b000;
        ALU_ASel  = 1'b0;
        ALU_BSel  = 3'b000;
        ALUOp     = 3'b000;
        EXTOp     = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                IR_WE = 1'b1;
                PC_WE = 1'b1;
            end
            DECODE: illegal = !is_legal;
            EXEC: begin
                if (is_subu) ALUOp = 3'b001;
                if (is_ori) begin
                    ALUOp    = 3'b010;
                    ALU_BSel = 3'b001;
                end
                if (is_lui) begin
                    ALU_ASel = 1'b1;
                    ALUOp    = 3'b011;
                    ALU_BSel = 3'b001;
                end
                if (is_lw || is_sw) begin
                    ALU_BSel = 3'b001;
                    EXTOp    = 1'b1;
                end
                if (is_beq) begin
                    ALUOp = 3'b001;
                    EXTOp = 1'b1;
                    PC_WE = zero;
                    NPCOp = 2'b01;
                end
                if (is_jr) begin
                    PC_WE = 1'b1;
                    NPCOp = 2'b11;
                end
            end
            MEM: begin
                dm_req = 1'b1;
                DM_WE  = is_sw;
            end
            WB: begin
                GRF_WE = 1'b1;
                if (is_r) GRF_A3Sel = 3'b001;
                if (is_lw) GRF_WDSel = 3'b001;
                if (is_jal) begin
                    GRF_A3Sel = 3'b010;
                    GRF_WDSel = 3'b010;
                    PC_WE     = 1'b1;
                    NPCOp     = 2'b10;
                end
            end
            default: ;
        endcase
        // Reset must never let a write escape, whatever state is held.
        if (reset) begin
            PC_WE   = 1'b0;
            IR_WE   = 1'b0;
            GRF_WE  = 1'b0;
            DM_WE   = 1'b0;
            dm_req  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-instruction reference model queues the
// expected outputs of every cycle; a negedge monitor pops and compares.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, dm_ack;
    logic [5:0]  opcode, funct;
    logic        PC_WE, IR_WE, GRF_WE, DM_WE, dm_req, ALU_ASel, EXTOp, illegal;
    logic [1:0]  NPCOp;
    logic [2:0]  GRF_WDSel, GRF_A3Sel, ALU_BSel, ALUOp;
    logic [31:0] instr_cnt;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .dm_ack(dm_ack), .PC_WE(PC_WE), .NPCOp(NPCOp), .IR_WE(IR_WE),
        .GRF_WE(GRF_WE), .DM_WE(DM_WE), .dm_req(dm_req), .GRF_WDSel(GRF_WDSel),
        .GRF_A3Sel(GRF_A3Sel), .ALU_ASel(ALU_ASel), .ALU_BSel(ALU_BSel),
        .ALUOp(ALUOp), .EXTOp(EXTOp), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    typedef struct packed {
        logic        pc_we;
        logic [1:0]  npc;
        logic        ir_we, grf_we, dm_we, dm_req;
        logic [2:0]  wdsel, a3sel;
        logic        asel;
        logic [2:0]  bsel, aluop;
        logic        extop, illegal;
        logic [31:0] cnt;
    } exp_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4,
                   K_LW = 5, K_SW = 6, K_BEQ = 7, K_JAL = 8, K_ILL = 9;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_chk = 0, n_fail = 0;
    logic [31:0] m_cnt;
    exp_t  act;

    assign act = '{PC_WE, NPCOp, IR_WE, GRF_WE, DM_WE, dm_req, GRF_WDSel, GRF_A3Sel,
                   ALU_ASel, ALU_BSel, ALUOp, EXTOp, illegal, instr_cnt};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got %h expected %h", t, $time, act, e);
            end
        end
    end

    function automatic exp_t blank();
        exp_t e;
        e = '0;
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic cyc(input exp_t e, input string t, input logic ack);
        dm_ack = ack;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic set_enc(input int kind, input logic [5:0] ill_op);
        funct = 6'($urandom);
        case (kind)
            K_ADDU: begin opcode = 6'b000000; funct = 6'b100001; end
            K_SUBU: begin opcode = 6'b000000; funct = 6'b100011; end
            K_JR:   begin opcode = 6'b000000; funct = 6'b001000; end
            K_ORI:  opcode = 6'b001101;
            K_LUI:  opcode = 6'b001111;
            K_LW:   opcode = 6'b100011;
            K_SW:   opcode = 6'b101011;
            K_BEQ:  opcode = 6'b000100;
            K_JAL:  opcode = 6'b000011;
            default: begin
                opcode = ill_op;
                if (ill_op == 6'b000000) funct = 6'b000000;
            end
        endcase
    endtask

    // Expected per-cycle behaviour of one instruction, straight from the ISA rules.
    task automatic run_instr(input int kind, input logic z, input int k, input logic [5:0] ill_op);
        exp_t e;
        set_enc(kind, ill_op);
        zero = z;
        e = blank(); e.pc_we = 1; e.ir_we = 1;
        cyc(e, "fetch", 1'($urandom));
        e = blank(); e.illegal = (kind == K_ILL);
        cyc(e, "decode", 1'($urandom));
        if (kind == K_ILL) return;
        if (kind == K_JAL) begin
            e = blank(); e.grf_we = 1; e.a3sel = 3'd2; e.wdsel = 3'd2; e.pc_we = 1; e.npc = 2'd2;
            cyc(e, "jal_wb", 1'($urandom));
            m_cnt++;
            return;
        end
        e = blank();
        case (kind)
            K_SUBU: e.aluop = 3'd1;
            K_ORI:  begin e.aluop = 3'd2; e.bsel = 3'd1; end
            K_LUI:  begin e.asel = 1; e.aluop = 3'd3; e.bsel = 3'd1; end
            K_LW, K_SW: begin e.bsel = 3'd1; e.extop = 1; end
            K_BEQ:  begin e.aluop = 3'd1; e.extop = 1; e.pc_we = z; e.npc = 2'd1; end
            K_JR:   begin e.pc_we = 1; e.npc = 2'd3; end
            default: ;
        endcase
        cyc(e, "exec", 1'($urandom));
        if (kind == K_BEQ || kind == K_JR) begin
            m_cnt++;
            return;
        end
        if (kind == K_LW || kind == K_SW) begin
            e = blank(); e.dm_req = 1; e.dm_we = (kind == K_SW);
            for (int i = 0; i < k; i++) cyc(e, "mem_stall", 1'b0);
            cyc(e, "mem_ack", 1'b1);
            if (kind == K_SW) begin
                m_cnt++;
                return;
            end
        end
        e = blank(); e.grf_we = 1;
        e.a3sel = (kind == K_ADDU || kind == K_SUBU) ? 3'd1 : 3'd0;
        e.wdsel = (kind == K_LW) ? 3'd1 : 3'd0;
        cyc(e, "wb", 1'($urandom));
        m_cnt++;
    endtask

    logic [5:0] ill_ops [3] = '{6'b111111, 6'b000000, 6'b001000};

    initial begin
        exp_t e;
        reset = 1; opcode = '0; funct = '0; zero = 0; dm_ack = 0; m_cnt = '0;
        @(posedge clk); #1;
        cyc(blank(), "reset_state", 1'b1);
        reset = 0;

        run_instr(K_ADDU, 0, 0, 6'h3f);
        run_instr(K_LW, 0, 2, 6'h3f);
        run_instr(K_BEQ, 1, 0, 6'h3f);
        run_instr(K_BEQ, 0, 0, 6'h3f);
        run_instr(K_JAL, 0, 0, 6'h3f);
        run_instr(K_ILL, 0, 0, 6'b111111);
        run_instr(K_SW, 0, 1, 6'h3f);

        for (int n = 0; n < 60; n++)
            run_instr($urandom_range(0, 9), 1'($urandom), $urandom_range(0, 3),
                      ill_ops[$urandom_range(0, 2)]);

        // sw abandoned by reset while dm_ack is high in MEM
        set_enc(K_SW, 6'h3f);
        e = blank(); e.pc_we = 1; e.ir_we = 1; cyc(e, "rst_fetch", 1'b0);
        cyc(blank(), "rst_decode", 1'b1);
        e = blank(); e.bsel = 3'd1; e.extop = 1; cyc(e, "rst_exec", 1'b0);
        reset = 1;
        cyc(blank(), "rst_in_mem", 1'b1);
        reset = 0;
        m_cnt = '0;
        run_instr(K_ORI, 0, 0, 6'h3f);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        run_instr(K_ORI, 0, 0, 6'h3f);
        run_instr(K_ORI, 0, 0, 6'h3f);
        run_instr(K_ADDU, 0, 0, 6'h3f);

        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
